// File: rtl/pe_array_sequencer.sv
// Control sequencer for one systolic PE tile: C preload, operand injection,
// pipeline flush, optional INT4 combine pass, and result drain.
//
// state     | meaning
// S_IDLE    | waiting for a legal start
// S_LOAD    | preloading NREG C words into every PE regfile
// S_INJECT  | edge enable high for k_len beats
// S_FLUSH   | letting the operand wavefront clear the array
// S_COMBINE | single-cycle INT4 combine enable at the edge
// S_WAVE    | combine wavefront propagating across the array
// S_DRAIN   | streaming NREG accumulator words out
// S_DONE    | one-cycle completion pulse
module pe_array_sequencer #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int NREG = 4,
    parameter int KW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    datatype,
    input  logic          mixed,
    input  logic [KW-1:0] k_len,
    input  logic          c_valid,
    output logic          c_ready,
    output logic          pe_we,
    output logic          pe_en,
    output logic          pe_cm,
    output logic          pe_wben,
    output logic          pe_mixed,
    output logic [1:0]    pe_datatype,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int WW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int FW = $clog2(ROWS + COLS + 2);
    localparam logic [1:0]    DT_INT4   = 2'd3;
    localparam logic [WW-1:0] WORD_LAST = WW'(NREG - 1);
    localparam logic [FW-1:0] WAVE_LAST = FW'(ROWS + COLS - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INJECT, S_FLUSH, S_COMBINE, S_WAVE, S_DRAIN, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] word_cnt, word_cnt_nxt;
    logic [KW-1:0] inj_cnt, inj_cnt_nxt;
    logic [FW-1:0] wait_cnt, wait_cnt_nxt;
    logic [KW-1:0] k_q;
    logic [1:0]    dt_q;
    logic          mixed_q;
    logic          err_nxt;
    logic          latch_en;
    logic          start_bad;
    logic [FW-1:0] flush_last;

    // FP formats must keep the 4-deep regfile pointer aligned, so k_len % 4 == 0
    assign start_bad  = (k_len == '0) || (!datatype[1] && (k_len[1:0] != 2'b00));
    assign flush_last = WAVE_LAST + {{(FW-1){1'b0}}, ~dt_q[1]};

    assign pe_datatype = dt_q;
    assign pe_mixed    = mixed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            inj_cnt  <= '0;
            wait_cnt <= '0;
            k_q      <= '0;
            dt_q     <= '0;
            mixed_q  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            inj_cnt  <= inj_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            err      <= err_nxt;
            if (latch_en) begin
                k_q     <= k_len;
                dt_q    <= datatype;
                mixed_q <= mixed;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        inj_cnt_nxt  = inj_cnt;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err;
        latch_en     = 1'b0;
        c_ready      = 1'b0;
        pe_we        = 1'b0;
        pe_en        = 1'b0;
        pe_cm        = 1'b0;
        pe_wben      = 1'b0;
        done         = 1'b0;
        busy         = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        err_nxt      = 1'b0;
                        latch_en     = 1'b1;
                        word_cnt_nxt = WORD_LAST;
                        state_nxt    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                c_ready = c_valid;
                pe_we   = c_valid;
                if (c_valid) begin
                    if (word_cnt == '0) begin
                        inj_cnt_nxt = k_q - KW'(1);
                        state_nxt   = S_INJECT;
                    end else begin
                        word_cnt_nxt = word_cnt - WW'(1);
                    end
                end
            end
            S_INJECT: begin
                pe_en = 1'b1;
                if (inj_cnt == '0) begin
                    wait_cnt_nxt = flush_last;
                    state_nxt    = S_FLUSH;
                end else begin
                    inj_cnt_nxt = inj_cnt - KW'(1);
                end
            end
            S_FLUSH: begin
                if (wait_cnt == '0) begin
                    if (dt_q == DT_INT4) begin
                        state_nxt = S_COMBINE;
                    end else begin
                        word_cnt_nxt = WORD_LAST;
                        state_nxt    = S_DRAIN;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt - FW'(1);
                end
            end
            S_COMBINE: begin
                pe_cm        = 1'b1;
                wait_cnt_nxt = WAVE_LAST;
                state_nxt    = S_WAVE;
            end
            S_WAVE: begin
                if (wait_cnt == '0) begin
                    word_cnt_nxt = WORD_LAST;
                    state_nxt    = S_DRAIN;
                end else begin
                    wait_cnt_nxt = wait_cnt - FW'(1);
                end
            end
            S_DRAIN: begin
                pe_wben = 1'b1;
                if (out_ready) begin
                    if (word_cnt == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        word_cnt_nxt = word_cnt - WW'(1);
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer: per-phase cycle counts, backpressure,
// error handling, async reset abort and ignored restarts.
module tb_pe_array_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NREG = 4;
    localparam int KW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    datatype = 2'd0;
    logic          mixed = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          c_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          c_ready, pe_we, pe_en, pe_cm, pe_wben, pe_mixed;
    logic [1:0]    pe_datatype;
    logic          busy, done, err;

    always #5 clk = ~clk;

    pe_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .NREG(NREG), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .datatype(datatype), .mixed(mixed),
        .k_len(k_len), .c_valid(c_valid), .c_ready(c_ready), .pe_we(pe_we),
        .pe_en(pe_en), .pe_cm(pe_cm), .pe_wben(pe_wben), .pe_mixed(pe_mixed),
        .pe_datatype(pe_datatype), .out_ready(out_ready), .busy(busy),
        .done(done), .err(err)
    );

    int total = 0;
    int passed = 0;

    int n_we, n_en, n_cm, n_wben, last_en, first_cm, first_wben;
    int done_cyc, n_done, busy_low, excl_bad, we_bad, dt_bad, err_seen;
    int timeout, busy_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drives one op from its start cycle (cycle 0) to the done cycle and
    // records what every control line did along the way.
    task automatic run_op(input logic [1:0] dt, input logic mx, input logic [KW-1:0] k,
                          input int cv_len, input logic [15:0] cv_pat,
                          input int or_len, input logic [15:0] or_pat,
                          input int restart_at);
        int  d;
        bit  fin;
        n_we = 0; n_en = 0; n_cm = 0; n_wben = 0; last_en = -1; first_cm = -1;
        first_wben = -1; done_cyc = -1; n_done = 0; busy_low = 0; excl_bad = 0;
        we_bad = 0; dt_bad = 0; err_seen = 0; timeout = 0; busy_after = -1;
        d = 0;
        fin = 1'b0;
        @(negedge clk);
        start = 1'b1; datatype = dt; mixed = mx; k_len = k;
        c_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                start    = (cyc == restart_at);
                k_len    = (cyc == restart_at) ? '0 : k;
                datatype = dt ^ 2'b11;
                mixed    = ~mx;
                c_valid  = (cyc - 1 < cv_len) ? cv_pat[cyc-1] : 1'b1;
                out_ready = (d < or_len) ? or_pat[d] : 1'b1;
            end
            #1;
            if (cyc > 0) begin
                if (busy !== 1'b1) busy_low++;
                if (int'(pe_we) + int'(pe_en) + int'(pe_cm) + int'(pe_wben) > 1) excl_bad++;
                if (pe_we && !c_valid) we_bad++;
                if (pe_we) n_we++;
                if (pe_en) begin n_en++; last_en = cyc; end
                if (pe_cm) begin n_cm++; if (first_cm < 0) first_cm = cyc; end
                if (pe_wben) begin n_wben++; d++; if (first_wben < 0) first_wben = cyc; end
                if (pe_datatype !== dt || pe_mixed !== mx) dt_bad++;
                if (err !== 1'b0) err_seen++;
                if (done) begin n_done++; done_cyc = cyc; fin = 1'b1; end
            end
        end
        if (!fin) timeout = 1;
        @(negedge clk);
        start = 1'b0;
        #1;
        busy_after = busy;
        if (done) n_done++;
    endtask

    task automatic check_op(input string name, input int e_we, input int e_en,
                            input int e_cm, input int e_wben, input int e_flush,
                            input int e_done);
        int flush;
        flush = (n_cm > 0) ? (first_cm - last_en - 1) : (first_wben - last_en - 1);
        check({name, "_timeout"}, timeout, 0);
        check({name, "_we"}, n_we, e_we);
        check({name, "_en"}, n_en, e_en);
        check({name, "_cm"}, n_cm, e_cm);
        check({name, "_wben"}, n_wben, e_wben);
        check({name, "_flush"}, flush, e_flush);
        check({name, "_done_cyc"}, done_cyc, e_done);
        check({name, "_n_done"}, n_done, 1);
        check({name, "_busy_low"}, busy_low, 0);
        check({name, "_excl"}, excl_bad, 0);
        check({name, "_we_align"}, we_bad, 0);
        check({name, "_dt_stable"}, dt_bad, 0);
        check({name, "_err"}, err_seen, 0);
        check({name, "_busy_after"}, busy_after, 0);
    endtask

    initial begin
        // reset state, with c_valid high to show c_ready stays low outside LOAD
        c_valid = 1'b1;
        out_ready = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ctrl", {c_ready, pe_we, pe_en, pe_cm, pe_wben}, 0);
        check("rst_latched", {pe_mixed, pe_datatype}, 0);
        @(negedge clk);
        rst = 1'b1;

        // INT8 k=8: 4 + 8 + 7 + 4 cycles, done at cycle 1+4+8+7+4+1-1 counting start as cycle 0
        run_op(2'd2, 1'b0, 8'd8, 0, 16'h0, 0, 16'h0, -1);
        check_op("int8", 4, 8, 0, 4, 7, 24);

        // FP32 k=4: flush gets the extra MAC stage -> 8 cycles
        run_op(2'd0, 1'b0, 8'd4, 0, 16'h0, 0, 16'h0, -1);
        check_op("fp32", 4, 4, 0, 4, 8, 21);

        // FP16 k=6 is rejected
        @(negedge clk);
        start = 1'b1; datatype = 2'd1; mixed = 1'b1; k_len = 8'd6;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("fp16_bad_err", err, 1);
        check("fp16_bad_busy", busy, 0);
        @(negedge clk);
        #1;
        check("fp16_bad_busy2", busy, 0);

        // INT4 k=2: flush 7, combine 1, wavefront wait 7, drain 4
        run_op(2'd3, 1'b0, 8'd2, 0, 16'h0, 0, 16'h0, -1);
        check_op("int4", 4, 2, 1, 4, 7, 26);
        check("int4_wave", first_wben - first_cm - 1, 7);

        // backpressure: c_valid 1,0,0,1,1,0,1 and out_ready 0,1,0,1,1,1; restart pulse in DRAIN
        run_op(2'd2, 1'b1, 8'd1, 7, 16'b1011001, 6, 16'b111010, 17);
        check_op("bp", 4, 1, 0, 6, 7, 22);

        // k_len=0 start sets err, then a legal start clears it
        @(negedge clk);
        start = 1'b1; datatype = 2'd2; k_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("k0_err", err, 1);
        check("k0_busy", busy, 0);
        run_op(2'd2, 1'b0, 8'd3, 0, 16'h0, 0, 16'h0, -1);
        check_op("after_k0", 4, 3, 0, 4, 7, 19);

        // async reset mid-INJECT, not aligned to a clock edge
        @(negedge clk);
        start = 1'b1; datatype = 2'd2; mixed = 1'b1; k_len = 8'd8; c_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("mid_inject_en", pe_en, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ctrl", {c_ready, pe_we, pe_en, pe_cm, pe_wben}, 0);
        check("arst_busy_done", {busy, done}, 0);
        check("arst_latched", {pe_mixed, pe_datatype}, 0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2'd2, 1'b0, 8'd8, 0, 16'h0, 0, 16'h0, -1);
        check_op("post_rst", 4, 8, 0, 4, 7, 24);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
